// File: rtl/vita49_trig_sched.sv
// vita49_trig_sched: timed window gate for a VITA-49 AXI-Stream sample path.
// Windows {start tsi, start tsf, beats} are queued through cmd_*. The gate opens
// one cycle after {tsi,tsf} reaches the start time. It passes cmd_beats handshakes
// and then closes. Entries that are already late at load time are dropped.
// Ports: S_AXIS_* in -> M_AXIS_* out (gated), cmd_* schedule push, tsi/tsf time,
//        gate_open/done/late/fifo_level/late_cnt/state status.
// Optional macro VITA49_TRIG_SCHED_PKT_ALIGN_EN: close on TLAST after the count.
module vita49_trig_sched #(
  parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int unsigned C_CNT_W                = 16,
  parameter int unsigned C_DEPTH_LOG2           = 2
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  input  logic                                enable,
  input  logic                                abort,
  input  logic [31:0]                         cmd_tsi,
  input  logic [63:0]                         cmd_tsf,
  input  logic [C_CNT_W-1:0]                  cmd_beats,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [31:0]                         tsi,
  input  logic [63:0]                         tsf,
  output logic                                gate_open,
  output logic                                done,
  output logic                                late,
  output logic [C_DEPTH_LOG2:0]               fifo_level,
  output logic [15:0]                         late_cnt,
  output logic [2:0]                          state
);

  localparam int unsigned DEPTH = 2**C_DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARMED = 3'd2,
    OPEN  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t st, st_nxt;

  logic [31:0]          q_tsi   [DEPTH];
  logic [63:0]          q_tsf   [DEPTH];
  logic [C_CNT_W-1:0]   q_beats [DEPTH];
  logic [C_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;

  logic [31:0]          act_tsi;
  logic [63:0]          act_tsf;
  logic [C_CNT_W-1:0]   act_beats, cnt, cnt_inc;
  logic [95:0]          now_t, start_t;

  logic gate_q, gate_nxt, done_nxt, late_nxt, cnt_clr, cnt_en, hs;

  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign M_AXIS_TVALID = S_AXIS_TVALID & gate_q;
  assign S_AXIS_TREADY = M_AXIS_TREADY & gate_q;

  assign hs         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign fifo_level = wr_ptr - rd_ptr;
  // Level never exceeds DEPTH, so its MSB alone flags full.
  assign full       = fifo_level[C_DEPTH_LOG2];
  assign empty      = (fifo_level == '0);
  assign cmd_ready  = ~full & ~abort;
  assign push       = cmd_valid & cmd_ready;

  assign now_t     = {tsi, tsf};
  assign start_t   = {act_tsi, act_tsf};
  assign cnt_inc   = cnt + 1'b1;
  assign gate_open = gate_q;
  assign state     = st;

  always_comb begin
    st_nxt   = st;
    gate_nxt = gate_q;
    done_nxt = 1'b0;
    late_nxt = 1'b0;
    pop      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (abort) begin
      st_nxt   = IDLE;
      gate_nxt = 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (enable && !empty) begin
            pop    = 1'b1;
            st_nxt = LOAD;
          end
        end
        LOAD: begin
          if (now_t > start_t) begin
            late_nxt = 1'b1;
            st_nxt   = IDLE;
          end else begin
            st_nxt = ARMED;
          end
        end
        ARMED: begin
          if (now_t >= start_t) begin
            if (act_beats == '0) begin
              done_nxt = 1'b1;
              st_nxt   = IDLE;
            end else begin
              gate_nxt = 1'b1;
              cnt_clr  = 1'b1;
              st_nxt   = OPEN;
            end
          end
        end
        OPEN: begin
          if (hs) begin
            cnt_en = 1'b1;
            if (cnt_inc == act_beats) begin
`ifdef VITA49_TRIG_SCHED_PKT_ALIGN_EN
              if (S_AXIS_TLAST) begin
                gate_nxt = 1'b0;
                done_nxt = 1'b1;
                st_nxt   = IDLE;
              end else begin
                st_nxt = DRAIN;
              end
`else
              gate_nxt = 1'b0;
              done_nxt = 1'b1;
              st_nxt   = IDLE;
`endif
            end
          end
        end
        DRAIN: begin
          if (hs && S_AXIS_TLAST) begin
            gate_nxt = 1'b0;
            done_nxt = 1'b1;
            st_nxt   = IDLE;
          end
        end
        default: begin
          gate_nxt = 1'b0;
          st_nxt   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      st        <= IDLE;
      gate_q    <= 1'b0;
      done      <= 1'b0;
      late      <= 1'b0;
      late_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      act_tsi   <= '0;
      act_tsf   <= '0;
      act_beats <= '0;
      cnt       <= '0;
    end else begin
      st     <= st_nxt;
      gate_q <= gate_nxt;
      done   <= done_nxt;
      late   <= late_nxt;
      if (late_nxt && (late_cnt != '1)) begin
        late_cnt <= late_cnt + 1'b1;
      end
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        act_tsi   <= q_tsi[rd_ptr[C_DEPTH_LOG2-1:0]];
        act_tsf   <= q_tsf[rd_ptr[C_DEPTH_LOG2-1:0]];
        act_beats <= q_beats[rd_ptr[C_DEPTH_LOG2-1:0]];
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_en) begin
        cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (push) begin
      q_tsi[wr_ptr[C_DEPTH_LOG2-1:0]]   <= cmd_tsi;
      q_tsf[wr_ptr[C_DEPTH_LOG2-1:0]]   <= cmd_tsf;
      q_beats[wr_ptr[C_DEPTH_LOG2-1:0]] <= cmd_beats;
    end
  end

endmodule
